sipo_deserializer: RTL and testbench

//   Serial-in/parallel-out deserializer; the receive-side counterpart of the PISO serializer.

---
 rtl/sipo_deserializer.sv | 92 +++++++++
 tb/tb_sipo_deserializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: gathers SIZE enabled bits into a word
// and hands the word to a valid/ready consumer through a one-word holding register.
module sipo_deserializer #(
    parameter int SIZE      = 8,
    parameter bit SHIFT_DIR = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in,
    input  logic            enable,
    output logic [SIZE-1:0] out,
    output logic            valid,
    input  logic            ready,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    logic [CW-1:0]   bit_count_q, bit_count_d, wr_idx;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [SIZE-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            done_q;
    logic            overrun_q, overrun_d;
    logic            complete, accept;

    // MSB-first mode mirrors the write position; the count itself always runs upward.
    assign wr_idx   = SHIFT_DIR ? (LAST - bit_count_q) : bit_count_q;
    assign complete = enable && (bit_count_q == LAST);
    assign accept   = valid_q && ready;

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_shreg
            assign shreg_d[gi] = (enable && (wr_idx == CW'(gi))) ? in : shreg_q[gi];
        end
    endgenerate

    always_comb begin
        bit_count_d = bit_count_q;
        if (complete) begin
            bit_count_d = '0;
        end else if (enable) begin
            bit_count_d = bit_count_q + 1'b1;
        end
    end

    // shreg_d already contains the final bit, so it is the completed word.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (complete) begin
            if (!valid_q || accept) begin
                out_d   = shreg_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count_q <= '0;
            shreg_q     <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bit_count_q <= bit_count_d;
            shreg_q     <= shreg_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            done_q      <= complete;
            overrun_q   <= overrun_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign busy    = (bit_count_q != '0);
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one LSB-first and one MSB-first instance
// share the serial stimulus and are checked against hand-computed words.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_in;
    logic       enable;
    logic       ready;
    logic [7:0] out0, out1;
    logic       valid0, valid1, busy0, busy1, done0, done1, ovr0, ovr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.SIZE(8), .SHIFT_DIR(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in(ser_in), .enable(enable), .out(out0),
        .valid(valid0), .ready(ready), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    sipo_deserializer #(.SIZE(8), .SHIFT_DIR(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .in(ser_in), .enable(enable), .out(out1),
        .valid(valid1), .ready(ready), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    // stream[i] is the i-th bit on the wire; gaps = idle cycles after each non-final bit.
    typedef struct {
        logic [7:0] stream;
        int         gaps;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic b,
                             input logic d, input logic o);
        chk({tag, ".valid_lsb"},   {7'd0, valid0}, {7'd0, v});
        chk({tag, ".valid_msb"},   {7'd0, valid1}, {7'd0, v});
        chk({tag, ".busy"},        {6'd0, busy1, busy0}, {6'd0, b, b});
        chk({tag, ".done"},        {6'd0, done1, done0}, {6'd0, d, d});
        chk({tag, ".overrun"},     {6'd0, ovr1, ovr0}, {6'd0, o, o});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Drives one word; checks busy/done on every non-final cycle. ready switches to
    // rdy_last for the edge that samples the final bit. Caller checks the completion edge.
    task automatic send_word(input logic [7:0] s, input int gaps, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            ser_in = s[i];
            enable = 1'b1;
            if (i == 7) ready = rdy_last;
            tick();
            if (i < 7) begin
                checks++;
                if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 || done1 !== 1'b0) begin
                    errors++;
                    $display("FAIL bit%0d busy/done: got busy=%b%b done=%b%b expected busy=11 done=00",
                             i, busy0, busy1, done0, done1);
                end
                enable = 1'b0;
                for (int g = 0; g < gaps; g++) begin
                    tick();
                    checks++;
                    if (busy0 !== 1'b1 || done0 !== 1'b0 || busy1 !== 1'b1) begin
                        errors++;
                        $display("FAIL gap%0d.%0d hold: got busy=%b done=%b expected busy=1 done=0",
                                 i, g, busy0, done0);
                    end
                end
            end
        end
        enable = 1'b0;
        $display("word stream=%h gaps=%0d -> lsb=%h msb=%h valid=%b done=%b ovr=%b",
                 s, gaps, out0, out1, valid0, done0, ovr0);
    endtask

    initial begin
        vecs[0] = '{stream: 8'h5A, gaps: 0, exp_lsb: 8'h5A, exp_msb: 8'h5A};
        vecs[1] = '{stream: 8'hC3, gaps: 0, exp_lsb: 8'hC3, exp_msb: 8'hC3};
        vecs[2] = '{stream: 8'h01, gaps: 0, exp_lsb: 8'h01, exp_msb: 8'h80};
        vecs[3] = '{stream: 8'h2C, gaps: 1, exp_lsb: 8'h2C, exp_msb: 8'h34};
        vecs[4] = '{stream: 8'h81, gaps: 2, exp_lsb: 8'h81, exp_msb: 8'h81};

        reset  = 1'b1;
        ser_in = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        tick();
        chk("reset.out_lsb", out0, 8'h00);
        chk("reset.out_msb", out1, 8'h00);
        chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset  = 1'b0;
        enable = 1'b0;
        tick();

        // Table: ready=1 throughout, word appears for exactly one cycle.
        for (int v = 0; v < 5; v++) begin
            send_word(vecs[v].stream, vecs[v].gaps, 1'b1);
            chk($sformatf("vec%0d.out_lsb", v), out0, vecs[v].exp_lsb);
            chk($sformatf("vec%0d.out_msb", v), out1, vecs[v].exp_msb);
            chk_flags($sformatf("vec%0d.done_edge", v), 1'b1, 1'b0, 1'b1, 1'b0);
            tick();
            chk($sformatf("vec%0d.out_hold", v), out0, vecs[v].exp_lsb);
            chk_flags($sformatf("vec%0d.after", v), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Overrun: consumer stalled across two words.
        ready = 1'b0;
        send_word(8'hA5, 0, 1'b0);
        chk("ovr.w1_out", out0, 8'hA5);
        chk_flags("ovr.w1", 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h3C, 0, 1'b0);
        chk("ovr.w2_out_lsb", out0, 8'hA5);
        chk("ovr.w2_out_msb", out1, 8'hA5);
        chk_flags("ovr.w2", 1'b1, 1'b0, 1'b1, 1'b1);
        ready = 1'b1;
        tick();
        chk("ovr.drain_out", out0, 8'hA5);
        chk_flags("ovr.drain", 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        chk_flags("ovr.sticky", 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_flags("ovr.cleared", 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: accept and completion on the same edge.
        ready = 1'b0;
        send_word(8'h12, 0, 1'b0);
        chk("b2b.w1_lsb", out0, 8'h12);
        chk("b2b.w1_msb", out1, 8'h48);
        send_word(8'hF0, 0, 1'b1);
        chk("b2b.w2_lsb", out0, 8'hF0);
        chk("b2b.w2_msb", out1, 8'h0F);
        chk_flags("b2b.w2", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_flags("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-word with a held word, then a clean word.
        ready = 1'b0;
        send_word(8'h3C, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ser_in = 1'b0;
            enable = 1'b1;
            tick();
        end
        chk_flags("mid.partial", 1'b1, 1'b1, 1'b0, 1'b0);
        reset  = 1'b1;
        ser_in = 1'b1;
        tick();
        chk("mid.rst_out_lsb", out0, 8'h00);
        chk("mid.rst_out_msb", out1, 8'h00);
        chk_flags("mid.rst", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        ready = 1'b1;
        send_word(8'hFF, 0, 1'b1);
        chk("mid.ff_lsb", out0, 8'hFF);
        chk("mid.ff_msb", out1, 8'hFF);
        chk_flags("mid.ff", 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
